// File: rtl/freq_sweep_tracker.sv
// rtl/freq_sweep_tracker.sv - linear frequency sweep keeping the point with the highest averaged ADC reading
// Optional fine pass around the coarse best point when FREQ_FINE_SWEEP_EN is defined.
module freq_sweep_tracker #(
    parameter int FREQ_W      = 20,
    parameter int ADC_W       = 12,
    parameter int STARTUP_CYC = 200000,
    parameter int SETTLE_CYC  = 200000,
    parameter int AVG_LOG2    = 3
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              swiptAlive,
    input  logic              freqAlgGo,
    input  logic [FREQ_W-1:0] freq,
    input  logic [FREQ_W-1:0] freqMin,
    input  logic [FREQ_W-1:0] freqMax,
    input  logic [FREQ_W-1:0] freqStep,
    input  logic [ADC_W-1:0]  adc,
    input  logic              adcValid,
    output logic [FREQ_W-1:0] newFreq,
    output logic [FREQ_W-1:0] bestFreq,
    output logic [ADC_W-1:0]  bestAdc,
    output logic              busy,
    output logic              freqAlgDone,
    output logic              freqErr
);
    localparam int ACC_W = ADC_W + AVG_LOG2;
    localparam int CNT_W = 32;
    localparam logic [AVG_LOG2:0] LAST_SMP = (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1);

`ifdef FREQ_FINE_SWEEP_EN
    typedef enum logic [2:0] {IDLE, STARTUP, SETTLE, SAMPLE, COMPARE, STEP, DONE, FINE_INIT} state_t;
`else
    typedef enum logic [2:0] {IDLE, STARTUP, SETTLE, SAMPLE, COMPARE, STEP, DONE} state_t;
`endif

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [ACC_W-1:0]  acc;
    logic [AVG_LOG2:0] scnt;
    logic [FREQ_W-1:0] min_r, max_r, step_r;
    logic [FREQ_W:0]   next_f;
    logic [ADC_W-1:0]  avg;

    assign next_f = {1'b0, newFreq} + {1'b0, step_r};
    assign avg    = acc[ACC_W-1:AVG_LOG2];
    assign busy   = (state != IDLE) && (state != DONE);

`ifdef FREQ_FINE_SWEEP_EN
    logic              is_fine;
    logic [FREQ_W-1:0] lo_raw, fine_lo, fine_hi, fine_step;
    logic [FREQ_W:0]   hi_raw;

    // Fine window is one coarse step either side of the best point, clipped to the coarse bounds
    assign lo_raw    = (bestFreq >= step_r) ? bestFreq - step_r : '0;
    assign fine_lo   = (lo_raw > min_r) ? lo_raw : min_r;
    assign hi_raw    = {1'b0, bestFreq} + {1'b0, step_r};
    assign fine_hi   = (hi_raw > {1'b0, max_r}) ? max_r : hi_raw[FREQ_W-1:0];
    assign fine_step = (step_r[FREQ_W-1:2] == '0) ? FREQ_W'(1) : (step_r >> 2);
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            scnt        <= '0;
            min_r       <= '0;
            max_r       <= '0;
            step_r      <= '0;
            newFreq     <= '0;
            bestFreq    <= '0;
            bestAdc     <= '0;
            freqAlgDone <= 1'b0;
            freqErr     <= 1'b0;
`ifdef FREQ_FINE_SWEEP_EN
            is_fine     <= 1'b0;
`endif
        end else if (!swiptAlive) begin
            state       <= IDLE;
            acc         <= '0;
            scnt        <= '0;
            bestAdc     <= '0;
            freqAlgDone <= 1'b0;
            freqErr     <= 1'b0;
            newFreq     <= freq;
            bestFreq    <= freq;
        end else if (busy && !freqAlgGo) begin
            state    <= IDLE;
            acc      <= '0;
            scnt     <= '0;
            newFreq  <= freq;
            bestFreq <= freq;
        end else begin
            case (state)
                IDLE: begin
                    newFreq  <= freq;
                    bestFreq <= freq;
                    if (freqAlgGo) begin
                        min_r       <= freqMin;
                        max_r       <= freqMax;
                        step_r      <= freqStep;
                        freqAlgDone <= 1'b0;
                        bestAdc     <= '0;
`ifdef FREQ_FINE_SWEEP_EN
                        is_fine     <= 1'b0;
`endif
                        if (freqStep == '0 || freqMin > freqMax) begin
                            freqErr     <= 1'b1;
                            freqAlgDone <= 1'b1;
                            state       <= DONE;
                        end else begin
                            freqErr <= 1'b0;
                            newFreq <= freqMin;
                            cnt     <= CNT_W'(STARTUP_CYC - 1);
                            state   <= STARTUP;
                        end
                    end
                end
                STARTUP, SETTLE: begin
                    if (cnt == '0) state <= SAMPLE;
                    else           cnt   <= cnt - 1'b1;
                end
                SAMPLE: begin
                    if (adcValid) begin
                        acc <= acc + ACC_W'(adc);
                        if (scnt == LAST_SMP) begin
                            scnt  <= '0;
                            state <= COMPARE;
                        end else begin
                            scnt <= scnt + 1'b1;
                        end
                    end
                end
                COMPARE: begin
                    if (avg > bestAdc) begin
                        bestAdc  <= avg;
                        bestFreq <= newFreq;
                    end
                    acc   <= '0;
                    state <= STEP;
                end
                STEP: begin
                    if (next_f[FREQ_W] || next_f[FREQ_W-1:0] > max_r) begin
`ifdef FREQ_FINE_SWEEP_EN
                        if (!is_fine) begin
                            state <= FINE_INIT;
                        end else begin
                            newFreq     <= bestFreq;
                            freqAlgDone <= 1'b1;
                            state       <= DONE;
                        end
`else
                        newFreq     <= bestFreq;
                        freqAlgDone <= 1'b1;
                        state       <= DONE;
`endif
                    end else begin
                        newFreq <= next_f[FREQ_W-1:0];
                        cnt     <= CNT_W'(SETTLE_CYC - 1);
                        state   <= SETTLE;
                    end
                end
`ifdef FREQ_FINE_SWEEP_EN
                FINE_INIT: begin
                    is_fine <= 1'b1;
                    newFreq <= fine_lo;
                    max_r   <= fine_hi;
                    step_r  <= fine_step;
                    cnt     <= CNT_W'(SETTLE_CYC - 1);
                    state   <= SETTLE;
                end
`endif
                DONE: begin
                    if (!freqAlgGo) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/freq_sweep_tracker.md
Name: freq_sweep_tracker

Overview:
- Parametrised successor to the single-step SWIPT frequency tuner.
- Performs a bounded linear frequency sweep from freqMin to freqMax in freqStep increments, with settle time after each retune and a 2^AVG_LOG2-sample ADC average per point.
- Retains the frequency with the highest averaged ADC reading and drives newFreq to it when done.
- Sits between the SWIPT supervisor (swiptAlive, freqAlgGo) and the transmitter's frequency synthesiser.

Parameters:
- FREQ_W, 20, width of all frequency buses.
- ADC_W, 12, ADC sample width.
- STARTUP_CYC, 200000, cycles to wait after run start before the first sample (2 ms at 100 MHz).
- SETTLE_CYC, 200000, cycles to wait after each frequency step before sampling.
- AVG_LOG2, 3, log2 of the number of ADC samples averaged per point.

Ports:
- clk, in, 1, system clock.
- nrst, in, 1, asynchronous active-low reset.
- swiptAlive, in, 1, link alive; low aborts everything.
- freqAlgGo, in, 1, run request (level).
- freq, in, FREQ_W, operating frequency used while idle.
- freqMin, in, FREQ_W, sweep start (latched at run start).
- freqMax, in, FREQ_W, sweep upper bound, inclusive.
- freqStep, in, FREQ_W, sweep increment.
- adc, in, ADC_W, ADC sample.
- adcValid, in, 1, adc qualifier, one sample per high cycle.
- newFreq, out, FREQ_W, frequency commanded to the synthesiser.
- bestFreq, out, FREQ_W, best frequency found so far.
- bestAdc, out, ADC_W, averaged ADC value at bestFreq.
- busy, out, 1, high in any state other than IDLE or DONE.
- freqAlgDone, out, 1, sweep complete.
- freqErr, out, 1, invalid configuration detected.

Behaviour:
- Clock and reset (already decided): one clock, clk; reset nrst is asynchronous, active-low.
- Reset values: all outputs 0; state IDLE; accumulator and counters 0.
- States: IDLE, STARTUP, SETTLE, SAMPLE, COMPARE, STEP, DONE.
- swiptAlive low (any state, synchronous, highest priority after nrst): go to IDLE; clear freqAlgDone, freqErr, bestAdc and the accumulator.
- IDLE: each cycle newFreq<=freq and bestFreq<=freq.
- IDLE to run start: on freqAlgGo high with swiptAlive high:
  - Latch freqMin, freqMax, freqStep.
  - Clear freqAlgDone, freqErr, bestAdc.
  - If freqStep==0 or freqMin>freqMax: go to DONE with freqErr=1; newFreq and bestFreq keep freq.
  - Otherwise newFreq<=freqMin, load counter STARTUP_CYC-1, go to STARTUP.
- STARTUP / SETTLE: decrement the counter each cycle; at 0 go to SAMPLE. Dwell is exactly STARTUP_CYC or SETTLE_CYC cycles.
- SAMPLE:
  - Accumulate adc on each adcValid cycle into an ADC_W+AVG_LOG2-bit accumulator (no overflow possible).
  - After the 2^AVG_LOG2-th valid sample go to COMPARE.
  - Cycles with adcValid low are not counted.
- COMPARE (1 cycle):
  - avg = acc>>AVG_LOG2 (truncating).
  - If avg > bestAdc (strict): bestAdc<=avg, bestFreq<=newFreq. Ties keep the earlier, lower frequency.
  - The first point always updates when avg>0; with an all-zero sweep, bestFreq stays at freq.
  - Clear the accumulator, then go to STEP.
- STEP (1 cycle):
  - next = newFreq + freqStep, computed at FREQ_W+1 bits.
  - If the carry is set or next > freqMax: newFreq<=bestFreq, go to DONE.
  - Otherwise newFreq<=next, load counter SETTLE_CYC-1, go to SETTLE.
- DONE:
  - freqAlgDone=1; newFreq and bestFreq are held.
  - When freqAlgGo goes low, go to IDLE. freqAlgDone stays 1 until the next run start or swiptAlive low.
  - In IDLE after DONE, newFreq resumes tracking freq.
- freqAlgGo low in STARTUP, SETTLE, SAMPLE, COMPARE or STEP: abort to IDLE; freqAlgDone stays 0; bestAdc is held.
- busy is combinational from state.

Optional Feature:
- Macro: FREQ_FINE_SWEEP_EN.
- Defined: instead of DONE after the coarse sweep, run one fine pass.
  - Bounds: lo = max(freqMin, bestFreq-freqStep), hi = min(freqMax, bestFreq+freqStep), with underflow-safe subtraction.
  - Step: max(freqStep>>2, 1).
  - Uses SETTLE, SAMPLE, COMPARE, STEP with bestAdc carried over; then DONE.
  - Adds internal state FINE_INIT and an isFine flag.
- Undefined: coarse sweep only, exactly as described in Behaviour.

Test Plan:
- Bench parameters: STARTUP_CYC=4, SETTLE_CYC=2, AVG_LOG2=1; adcValid always high.
- Basic sweep: min=100, max=140, step=10, adc model peaks at 120 (values 10, 20, 50, 30, 5) -> points 100..140 visited, bestFreq=120, bestAdc=50, newFreq=120, freqAlgDone=1, freqErr=0.
- Non-multiple bound: min=100, max=135, step=10 -> last point 130; 140 is never driven on newFreq.
- Invalid configuration: step=0, freq=500 -> next cycle DONE, freqErr=1, freqAlgDone=1, newFreq=500, busy never high.
- Overflow: min=0xFFFF0, max=0xFFFFF, step=0x10 -> exactly one point sampled, no wrap to 0, DONE.
- Abort: swiptAlive low during the SAMPLE at 120 -> next cycle IDLE, freqAlgDone=0, bestAdc=0, newFreq=freq. A freqAlgGo drop at the same point gives IDLE with bestAdc held.
- Tie and fine sweep: equal averages at 110 and 130 -> bestFreq=110. With FREQ_FINE_SWEEP_EN, step=8 and a peak at 122 -> fine pass visits 112..128 by 2, bestFreq=122.
